seg7_scan_mux: RTL
==================

# seg7_scan_mux

Four-digit multiplexed seven-segment display driver that sits downstream of the seconds/digit counters. Upstream logic hands it a 16-bit value (four 4-bit digits) plus decimal points through a valid/ready load port. The block decodes one digit at a time and cycles through the digit enables at a fixed scan rate. New values are committed only at frame boundaries, so a displayed frame never mixes old and new digits.

## Interface
- SCAN_DIV, 24'd10_000: clock cycles per digit slot (1 kHz per digit at 10 MHz); legal range 2 to 2^24-1.
- clk  input  1  system clock.
- reset  input  1  synchronous, active-high reset.
- load_valid  input  1  upstream presents load_value/load_dp/load_blank.
- load_ready  output  1  block can accept a load this cycle.
- load_value  input  16  digit n = load_value[4n+3:4n]; digit 0 is rightmost.
- load_dp  input  4  decimal point per digit, bit n for digit n, active high.
- load_blank  input  1  enable leading-zero blanking for this value.
- segments  output  7  segment drive, bit0=a … bit6=g, active high.
- dp  output  1  decimal point for the currently enabled digit.
- digit_en  output  4  one-hot digit enable, active high.
- frame_tick  output  1  one-cycle pulse after each frame commit edge.

## Operation
- Prescaler: 24-bit counter pre counts 0..SCAN_DIV-1, then wraps to 0. Scan tick = (pre == SCAN_DIV-1).
- Digit index idx (2 bits): advances 0→1→2→3→0 on each scan tick. Frame boundary = scan tick while idx == 3.
- Registers: pending (value, dp, blank, full flag) and display (value, dp, blank).
- Load handshake: load_ready = ~pending_full. A transfer occurs when load_valid & load_ready; the inputs are captured into pending and pending_full is set.
- Commit: on a frame-boundary edge with pending_full = 1, display ← pending and pending_full is cleared. With pending_full = 0, display holds.
- Accept and commit never coincide: ready is low whenever a commit is possible.
- Decode (combinational from display and idx): 0–9 as standard digits, 10–15 as hex A, b, C, d, E, F.
- digit_en = 1 << idx. dp = display_dp[idx].
- Leading-zero blanking: when display_blank = 1, digit n (n = 3, 2, 1) shows segments = 0 if it and every higher digit are zero. Digit 0 is never blanked. dp is unaffected by blanking.
- Reset values:
  - pre = 0, idx = 0, display = 0 with dp = 0 and blank = 0, pending cleared.
  - Outputs: load_ready = 1, digit_en = 4'b0001, segments = 7'b0111111 ("0"), dp = 0, frame_tick = 0.
- Reset mid-operation discards both the pending and the displayed value.

## Timing
- segments, dp and digit_en change only on the edge that updates idx or display. All three always refer to the same digit, with no cycle of skew.
- Digit slot = SCAN_DIV cycles. Frame = 4·SCAN_DIV cycles.
- Load-to-display latency:
  - From the accept edge to the next frame-boundary edge, i.e. 1 to 4·SCAN_DIV cycles.
  - The new digit 0 is visible in the cycle after the commit edge.
- load_ready drops the cycle after the accept edge. It rises the cycle after the commit edge, so the next accept is possible one cycle after the commit.
- frame_tick is registered. It is high for exactly the one cycle after every frame-boundary edge, whether or not a commit occurred.
- load_valid held high with load_ready low: inputs are ignored and no state changes.

## Test plan
- Reset, SCAN_DIV=4: after reset release, digit_en steps 0001→0010→0100→1000→0001 every 4 cycles. segments = 7'b0111111 throughout. frame_tick fires every 16 cycles.
- Load 16'h1234, dp=4'b0100, blank=0, mid-frame:
  - load_ready is low until the boundary.
  - After the commit: digit0 = 7'b1100110 ("4"), digit1 = "3", digit2 = "2" with dp=1, digit3 = "1".
  - load_ready rises the cycle after the commit.
- Load 16'h0070, blank=1: digits 3 and 2 show segments 0, digit1 = "7", digit0 = "0". With blank=0, digits 3 and 2 show "0".
- Back-to-back loads 16'hAAAA then 16'hBBBB with valid held high:
  - The second load is accepted one cycle after the first commits.
  - No frame mixes A and b.
  - Decodes: A = 7'b1110111, b = 7'b1111100.
- Reset asserted while pending_full=1 and idx=2: the next cycle shows idx=0, load_ready=1, display = "0", and the pending value never appears.
- Load accepted on the exact frame-boundary edge with pending empty: the commit happens at the following boundary, 4·SCAN_DIV cycles later.

Source files
------------

// File: rtl/seg7_load_if.sv
// Load port for seg7_scan_mux: one 4-digit value with decimal points and a
// leading-zero blanking flag, moved with a valid/ready handshake.
interface seg7_load_if;
    logic        valid;
    logic        ready;
    logic [15:0] value;
    logic [3:0]  dp;
    logic        blank;

    modport master (output valid, value, dp, blank, input ready);
    modport slave  (input valid, value, dp, blank, output ready);
endinterface

// File: rtl/seg7_scan_mux.sv
// Four-digit multiplexed seven-segment driver. A value loaded through the
// handshake port waits in a pending slot and is committed at a frame boundary.
module seg7_scan_mux #(
    parameter logic [23:0] SCAN_DIV = 24'd10_000
) (
    input  logic          i_clk,
    input  logic          i_reset,
    seg7_load_if.slave    load,
    output logic [6:0]    o_segments,
    output logic          o_dp,
    output logic [3:0]    o_digit_en,
    output logic          o_frame_tick
);
    localparam logic [23:0] LAST = SCAN_DIV - 24'd1;

    logic [23:0] r_pre;
    logic [1:0]  r_idx;
    logic [15:0] r_pend_val;
    logic [3:0]  r_pend_dp;
    logic        r_pend_blank;
    logic        r_pend_full;
    logic [15:0] r_disp_val;
    logic [3:0]  r_disp_dp;
    logic        r_disp_blank;
    logic        r_frame_tick;

    logic        w_scan_tick;
    logic        w_frame;
    logic        w_accept;
    logic [3:0]  w_zero;
    logic [3:0]  w_lz;
    logic [3:0]  w_nib;
    logic        w_blank;

    assign w_scan_tick = (r_pre == LAST);
    assign w_frame     = w_scan_tick && (r_idx == 2'd3);
    // ready is low whenever pending is full, so accept can never meet commit
    assign w_accept    = load.valid && !r_pend_full;
    assign load.ready  = ~r_pend_full;

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_pre        <= '0;
            r_idx        <= '0;
            r_pend_val   <= '0;
            r_pend_dp    <= '0;
            r_pend_blank <= 1'b0;
            r_pend_full  <= 1'b0;
            r_disp_val   <= '0;
            r_disp_dp    <= '0;
            r_disp_blank <= 1'b0;
            r_frame_tick <= 1'b0;
        end else begin
            r_pre        <= w_scan_tick ? 24'd0 : r_pre + 24'd1;
            r_frame_tick <= w_frame;
            if (w_scan_tick)
                r_idx <= r_idx + 2'd1;
            if (w_frame && r_pend_full) begin
                r_disp_val   <= r_pend_val;
                r_disp_dp    <= r_pend_dp;
                r_disp_blank <= r_pend_blank;
                r_pend_full  <= 1'b0;
            end else if (w_accept) begin
                r_pend_val   <= load.value;
                r_pend_dp    <= load.dp;
                r_pend_blank <= load.blank;
                r_pend_full  <= 1'b1;
            end
        end
    end

    // w_lz[n]: digit n and every digit above it are zero
    genvar g;
    generate
        for (g = 0; g < 4; g++) begin : g_zero
            assign w_zero[g] = (r_disp_val[4*g +: 4] == 4'd0);
        end
        for (g = 0; g < 3; g++) begin : g_lz
            assign w_lz[g] = w_zero[g] && w_lz[g+1];
        end
    endgenerate
    assign w_lz[3] = w_zero[3];

    assign w_nib   = r_disp_val[4*r_idx +: 4];
    assign w_blank = r_disp_blank && (r_idx != 2'd0) && w_lz[r_idx];

    always_comb begin
        o_segments = 7'b0000000;
        if (!w_blank) begin
            case (w_nib)
                4'h0: o_segments = 7'b0111111;
                4'h1: o_segments = 7'b0000110;
                4'h2: o_segments = 7'b1011011;
                4'h3: o_segments = 7'b1001111;
                4'h4: o_segments = 7'b1100110;
                4'h5: o_segments = 7'b1101101;
                4'h6: o_segments = 7'b1111101;
                4'h7: o_segments = 7'b0000111;
                4'h8: o_segments = 7'b1111111;
                4'h9: o_segments = 7'b1101111;
                4'hA: o_segments = 7'b1110111;
                4'hB: o_segments = 7'b1111100;
                4'hC: o_segments = 7'b0111001;
                4'hD: o_segments = 7'b1011110;
                4'hE: o_segments = 7'b1111001;
                default: o_segments = 7'b1110001;
            endcase
        end
    end

    assign o_dp         = r_disp_dp[r_idx];
    assign o_digit_en   = 4'b0001 << r_idx;
    assign o_frame_tick = r_frame_tick;
endmodule
